rx_deframer: RTL and testbench

RX_DEFRAMER -- requirements
Module: rx_deframer

---
 rtl/rx_deframer.sv | 152 +++++++++++++++
 tb/tb_rx_deframer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_deframer.sv
// rtl/rx_deframer.sv - HDLC receive deframer: flag/abort detection, zero-bit destuffing, byte assembly
module rx_deframer (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       RxEN,
  input  logic       Rx,
  output logic       Rx_FlagDetect,
  output logic       Rx_AbortDetect,
  output logic       Rx_ValidFrame,
  output logic [7:0] Rx_Data,
  output logic       Rx_NewByte,
  output logic       Rx_EoF,
  output logic       Rx_FrameError
);

  typedef enum logic [1:0] {S_IDLE, S_OPEN, S_FRAME} state_t;

  // Window holds the oldest bit in [0] and the newest in [7].
  localparam logic [7:0] FLAG_PAT  = 8'h7E;
  localparam logic [7:0] ABORT_PAT = 8'hFE;

  state_t     state_q, state_d;
  logic [7:0] win_q, win_d;
  logic       shifted_q, shifted_d;
  logic [2:0] fill_q, fill_d;
  logic [2:0] ones_q, ones_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] asm_q, asm_d;
  logic [7:0] data_q, data_d;
  logic       flag_q, flag_d;
  logic       abort_q, abort_d;
  logic       valid_q, valid_d;
  logic       newbyte_q, newbyte_d;
  logic       eof_q, eof_d;
  logic       ferr_q, ferr_d;

  logic       stage;
  logic       det_flag;
  logic       det_abort;
  logic       cand;
  logic [7:0] asm_next;

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    shifted_d = RxEN;
    fill_d    = fill_q;
    ones_d    = ones_q;
    idx_d     = idx_q;
    asm_d     = asm_q;
    data_d    = data_q;
    flag_d    = 1'b0;
    abort_d   = 1'b0;
    newbyte_d = 1'b0;
    eof_d     = 1'b0;
    ferr_d    = 1'b0;
    // Lags the state by one edge so the level stays up through the abort cycle.
    valid_d   = RxEN && (state_q == S_FRAME);

    // The compare runs one edge after the window was updated.
    stage     = RxEN && shifted_q;
    det_flag  = stage && (win_q == FLAG_PAT);
    det_abort = stage && (win_q == ABORT_PAT);
    cand      = win_q[0];
    asm_next  = {cand, asm_q[7:1]};

    if (RxEN) begin
      win_d = {Rx, win_q[7:1]};
    end

    if (!RxEN) begin
      state_d = S_IDLE;
      fill_d  = 3'd0;
    end else if (det_flag || det_abort) begin
      fill_d  = 3'd0;
      ones_d  = 3'd0;
      idx_d   = 3'd0;
      asm_d   = 8'h00;
      flag_d  = det_flag;
      abort_d = det_abort;
      if (det_abort) begin
        state_d = S_IDLE;
      end else begin
        state_d = S_OPEN;
        if (state_q == S_FRAME) begin
          eof_d  = 1'b1;
          ferr_d = (idx_q != 3'd0);
        end
      end
    end else if (stage) begin
      if (fill_q != 3'd7) begin
        fill_d = fill_q + 3'd1;
      end else if (state_q != S_IDLE) begin
        if (!cand && (ones_q == 3'd5)) begin
          ones_d = 3'd0;
        end else begin
          ones_d  = cand ? ((ones_q == 3'd5) ? 3'd5 : ones_q + 3'd1) : 3'd0;
          asm_d   = asm_next;
          idx_d   = idx_q + 3'd1;
          state_d = S_FRAME;
          if (idx_q == 3'd7) begin
            data_d    = asm_next;
            newbyte_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= S_IDLE;
      win_q     <= 8'hFF;
      shifted_q <= 1'b0;
      fill_q    <= 3'd0;
      ones_q    <= 3'd0;
      idx_q     <= 3'd0;
      asm_q     <= 8'h00;
      data_q    <= 8'h00;
      flag_q    <= 1'b0;
      abort_q   <= 1'b0;
      valid_q   <= 1'b0;
      newbyte_q <= 1'b0;
      eof_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      shifted_q <= shifted_d;
      fill_q    <= fill_d;
      ones_q    <= ones_d;
      idx_q     <= idx_d;
      asm_q     <= asm_d;
      data_q    <= data_d;
      flag_q    <= flag_d;
      abort_q   <= abort_d;
      valid_q   <= valid_d;
      newbyte_q <= newbyte_d;
      eof_q     <= eof_d;
      ferr_q    <= ferr_d;
    end
  end

  assign Rx_FlagDetect  = flag_q;
  assign Rx_AbortDetect = abort_q;
  assign Rx_ValidFrame  = valid_q;
  assign Rx_Data        = data_q;
  assign Rx_NewByte     = newbyte_q;
  assign Rx_EoF         = eof_q;
  assign Rx_FrameError  = ferr_q;

endmodule

// File: tb/tb_rx_deframer.sv
// tb/tb_rx_deframer.sv - directed bench for rx_deframer with a bit-stream reference model
module tb_rx_deframer;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       RxEN;
  logic       Rx;
  logic       Rx_FlagDetect;
  logic       Rx_AbortDetect;
  logic       Rx_ValidFrame;
  logic [7:0] Rx_Data;
  logic       Rx_NewByte;
  logic       Rx_EoF;
  logic       Rx_FrameError;

  rx_deframer dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .RxEN           (RxEN),
    .Rx             (Rx),
    .Rx_FlagDetect  (Rx_FlagDetect),
    .Rx_AbortDetect (Rx_AbortDetect),
    .Rx_ValidFrame  (Rx_ValidFrame),
    .Rx_Data        (Rx_Data),
    .Rx_NewByte     (Rx_NewByte),
    .Rx_EoF         (Rx_EoF),
    .Rx_FrameError  (Rx_FrameError)
  );

  always #5 Clk = ~Clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: keeps the received bit history and decodes it by pattern matching.
  bit         hist [0:8191];
  int         nb          = 0;
  int         reset_idx   = 0;
  int         since_det   = 0;
  bit         prev_shift  = 1'b0;
  int         m_state     = 0;
  int         ones        = 0;
  bit         fbits [$];
  bit         started     = 1'b0;
  bit         e_flag = 0, e_abort = 0, e_valid = 0, e_nb = 0, e_eof = 0, e_ferr = 0;
  logic [7:0] e_data = 8'h00;

  function automatic bit hbit(input int i);
    return (i < reset_idx) ? 1'b1 : hist[i];
  endfunction

  task automatic model_stage(input int k);
    string s;
    bit    b;
    s = "";
    for (int i = k - 7; i <= k; i++) begin
      if (hbit(i)) s = {s, "1"};
      else         s = {s, "0"};
    end
    if (s == "01111110") begin
      e_flag = 1'b1;
      if (m_state == 2) begin
        e_eof  = 1'b1;
        e_ferr = (fbits.size() % 8) != 0;
      end
      m_state = 1; since_det = 0; ones = 0; fbits.delete();
    end else if (s == "01111111") begin
      e_abort = 1'b1;
      m_state = 0; since_det = 0; ones = 0; fbits.delete();
    end else if (since_det < 7) begin
      since_det++;
    end else if (m_state != 0) begin
      b = hbit(k - 7);
      if (!b && ones >= 5) begin
        ones = 0;
      end else begin
        ones = b ? ones + 1 : 0;
        fbits.push_back(b);
        m_state = 2;
        if (fbits.size() % 8 == 0) begin
          e_nb = 1'b1;
          for (int i = 0; i < 8; i++) e_data[i] = fbits[fbits.size() - 8 + i];
        end
      end
    end
  endtask

  always @(posedge Clk) begin
    started = 1'b1;
    e_flag = 0; e_abort = 0; e_nb = 0; e_eof = 0; e_ferr = 0;
    e_valid = RxEN && !Rst && (m_state == 2);
    if (Rst) begin
      reset_idx = nb; since_det = 0; prev_shift = 0; m_state = 0; ones = 0;
      fbits.delete(); e_data = 8'h00;
    end else if (!RxEN) begin
      m_state = 0; since_det = 0; prev_shift = 0;
    end else begin
      if (prev_shift) model_stage(nb - 1);
      hist[nb] = Rx;
      nb++;
      prev_shift = 1'b1;
    end
  end

  // Event log captured from the DUT for the hand-computed checks.
  int         cyc = 0;
  int         flag_cnt, abort_cnt, eof_cnt, last_flag_cyc, abort_cyc;
  bit         last_ferr, abort_valid, post_abort_valid, valid_seen, nb_valid;
  logic [7:0] bytes [$];

  task automatic clear_logs();
    flag_cnt = 0; abort_cnt = 0; eof_cnt = 0; last_flag_cyc = -100; abort_cyc = -100;
    last_ferr = 0; abort_valid = 0; post_abort_valid = 1; valid_seen = 0; nb_valid = 1;
    bytes.delete();
  endtask

  task automatic tick(input bit rst, input bit en, input bit rx);
    logic [13:0] got, want;
    @(negedge Clk);
    cyc++;
    if (started) begin
      vectors++;
      got  = {Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_NewByte, Rx_EoF, Rx_FrameError, Rx_Data};
      want = {e_flag, e_abort, e_valid, e_nb, e_eof, e_ferr, e_data};
      if (got !== want) begin
        miscompares++;
        $display("FAIL model_compare cyc=%0d got flag/abort/valid/nb/eof/ferr/data=%b/%h want %b/%h",
                 cyc, got[13:8], got[7:0], want[13:8], want[7:0]);
      end
      if (Rx_FlagDetect)  begin flag_cnt++; last_flag_cyc = cyc; end
      if (abort_cyc == cyc - 1) post_abort_valid = Rx_ValidFrame;
      if (Rx_AbortDetect) begin abort_cnt++; abort_cyc = cyc; abort_valid = Rx_ValidFrame; end
      if (Rx_NewByte)     begin bytes.push_back(Rx_Data); nb_valid = nb_valid & Rx_ValidFrame; end
      if (Rx_EoF)         begin eof_cnt++; last_ferr = Rx_FrameError; end
      if (Rx_ValidFrame)  valid_seen = 1'b1;
    end
    Rst = rst; RxEN = en; Rx = rx;
  endtask

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic send(input bit b);
    tick(1'b0, 1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b1);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send(v[i]);
  endtask

  task automatic send_flag();
    send(1'b0);
    for (int i = 0; i < 6; i++) send(1'b1);
    send(1'b0);
  endtask

  int flag_end_cyc;

  initial begin
    Rst = 1'b1; RxEN = 1'b0; Rx = 1'b1;
    clear_logs();
    repeat (4) tick(1'b1, 1'b0, 1'b1);
    check("reset_outputs", {Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_NewByte,
                            Rx_EoF, Rx_FrameError, Rx_Data}, 0);
    idle(12);

    // Lone flag on an idle line; the idle 1s afterwards form an abort.
    clear_logs();
    send_flag();
    flag_end_cyc = cyc;
    idle(14);
    check("lone_flag_count", flag_cnt, 1);
    check("lone_flag_latency", last_flag_cyc - flag_end_cyc, 2);
    check("lone_flag_valid", valid_seen, 0);
    check("lone_flag_trailing_abort", abort_cnt, 1);
    check("lone_flag_eof", eof_cnt, 0);

    // Two-byte frame.
    clear_logs();
    send_flag(); send_byte(8'hA5); send_byte(8'h3C); send_flag();
    idle(14);
    check("two_byte_count", bytes.size(), 2);
    check("two_byte_first", bytes.size() > 0 ? int'(bytes[0]) : -1, 8'hA5);
    check("two_byte_second", bytes.size() > 1 ? int'(bytes[1]) : -1, 8'h3C);
    check("two_byte_valid_at_bytes", nb_valid, 1);
    check("two_byte_eof", eof_cnt, 1);
    check("two_byte_ferr", last_ferr, 0);

    // 0xFF with a stuffed zero after five 1s.
    clear_logs();
    send_flag();
    send(1); send(1); send(1); send(1); send(1); send(0); send(1); send(1); send(1);
    send_flag();
    idle(14);
    check("stuffed_count", bytes.size(), 1);
    check("stuffed_byte", bytes.size() > 0 ? int'(bytes[0]) : -1, 8'hFF);
    check("stuffed_eof", eof_cnt, 1);
    check("stuffed_ferr", last_ferr, 0);

    // Abort inside a frame.
    clear_logs();
    send_flag(); send_byte(8'hA5);
    send(1'b0); idle(7);
    idle(12);
    check("abort_count", abort_cnt, 1);
    check("abort_valid_same_cycle", abort_valid, 1);
    check("abort_valid_next_cycle", post_abort_valid, 0);
    check("abort_no_eof", eof_cnt, 0);
    check("abort_bytes", bytes.size(), 1);

    // Reset after four data bits.
    clear_logs();
    send_flag(); send(1); send(0); send(1); send(1);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    check("midframe_reset_outputs", {Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_NewByte,
                                     Rx_EoF, Rx_FrameError, Rx_Data}, 0);
    clear_logs();
    idle(20);
    check("post_reset_flag", flag_cnt, 0);
    check("post_reset_eof", eof_cnt, 0);
    check("post_reset_abort", abort_cnt, 0);

    // Twelve data bits: one byte then a frame error.
    clear_logs();
    send_flag(); send_byte(8'hA5); send(1); send(0); send(1); send(0); send_flag();
    idle(14);
    check("partial_bytes", bytes.size(), 1);
    check("partial_byte", bytes.size() > 0 ? int'(bytes[0]) : -1, 8'hA5);
    check("partial_eof", eof_cnt, 1);
    check("partial_ferr", last_ferr, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
